// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: start/busy/done handshake bundle (start, dividend, divisor in; busy, done, quotient, remainder, div_by_zero out)
interface seq_restoring_divider_if #(parameter int N = 8);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave  (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative unsigned restoring divider, one quotient bit per clock (ports: clk, rst_n, bus slave)
module seq_restoring_divider #(parameter int N = 8) (
  input  logic                        clk,
  input  logic                        rst_n,
  seq_restoring_divider_if.slave      bus
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q, state_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  sh_q, sh_d;
  logic [N-1:0]  dvsr_q, dvsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  remo_q, remo_d;
  logic          dbz_q, dbz_d;
  logic [N:0]    shifted, diff, new_rem;
  logic [N-1:0]  new_sh;
  logic          qbit;
  // partial remainder is always < divisor before the shift, so its bit N is zero and can be dropped
  assign shifted = {rem_q[N-1:0], sh_q[N-1]};
  assign diff    = shifted - {1'b0, dvsr_q};
  assign qbit    = ~diff[N];
  assign new_rem = qbit ? diff : shifted;
  assign new_sh  = {sh_q[N-2:0], qbit};
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    if (state_q == IDLE) begin
      if (bus.start) begin
        sh_d    = bus.dividend;
        dvsr_d  = bus.divisor;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
      end
    end else if (dvsr_q == '0) begin
      // zero divide completes on the first RUN edge; the shift register still holds the dividend
      done_d  = 1'b1;
      quot_d  = '1;
      remo_d  = sh_q;
      dbz_d   = 1'b1;
      state_d = IDLE;
    end else begin
      rem_d = new_rem;
      sh_d  = new_sh;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(N - 1)) begin
        done_d  = 1'b1;
        quot_d  = new_sh;
        remo_d  = new_rem[N-1:0];
        dbz_d   = 1'b0;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sh_q    <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbz_q;
endmodule
